// File: rtl/wdt_reset_requester.sv
// Watchdog and reset requester for the PicoBlaze subsystem. Optional lock-loss
// monitoring is compiled in when WDT_LOCK_MONITOR_EN is defined.
module wdt_reset_requester #(
  parameter logic [7:0] BASE_PORT = 8'h40,
  parameter int         PRESCALE  = 1000,
  parameter int         PULSE_LEN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       locked,
  output logic [7:0] in_port,
  output logic       reset_req,
  output logic       running
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
  localparam logic [7:0]  PULSE_LAST = 8'(PULSE_LEN - 1);
  localparam logic [7:0]  KICK_KEY   = 8'hA5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIRE} state_t;

  state_t      state, state_n;
  logic        en;
  logic        lockmon;
  logic [7:0]  reload;
  logic [7:0]  count;
  logic [15:0] presc;
  logic [7:0]  pulse_cnt;
  logic        wdt_cause = 1'b0;
  logic        lock_cause;
  logic        lock_trip;

  logic [7:0] sel;
  logic       wr, wr_ctrl, wr_reload, wr_kick, wr_status;
  logic       kick_ok, tick, terminal;
  logic       fire_wdt, fire_lock, fire_any;

  assign sel       = port_id - BASE_PORT;
  assign wr        = write_strobe && (state != S_FIRE);
  assign wr_ctrl   = wr && (sel == 8'd0);
  assign wr_reload = wr && (sel == 8'd1);
  assign wr_kick   = wr && (sel == 8'd2);
  assign wr_status = wr && (sel == 8'd3);
  assign kick_ok   = wr_kick && (out_port == KICK_KEY);
  assign tick      = (state == S_RUN) && (presc == PRESC_LAST);
  assign terminal  = tick && (count == 8'd0);

`ifdef WDT_LOCK_MONITOR_EN
  logic lock_low_q;
  logic lock_cause_q = 1'b0;

  // Two consecutive low samples of locked are required to trip.
  assign lock_trip  = lockmon && !locked && lock_low_q;
  assign lock_cause = lock_cause_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_low_q <= 1'b0;
      lockmon    <= 1'b0;
    end else begin
      lock_low_q <= !locked;
      if (wr_ctrl && !fire_any) lockmon <= out_port[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fire_lock)                    lock_cause_q <= 1'b1;
      else if (wr_status && out_port[1]) lock_cause_q <= 1'b0;
    end
  end
`else
  logic unused_locked;

  assign unused_locked = locked;
  assign lock_trip     = 1'b0;
  assign lockmon       = 1'b0;
  assign lock_cause    = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    fire_wdt  = 1'b0;
    fire_lock = 1'b0;
    case (state)
      S_IDLE: if (wr_ctrl && out_port[0]) state_n = S_RUN;
      S_RUN: begin
        // A disable write overrides every fire source in the same cycle.
        if (wr_ctrl && !out_port[0]) begin
          state_n = S_IDLE;
        end else begin
          fire_wdt  = terminal && !kick_ok;
          fire_lock = lock_trip;
          if (fire_wdt || fire_lock) state_n = S_FIRE;
        end
      end
      S_FIRE: if (pulse_cnt == PULSE_LAST) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign fire_any = fire_wdt || fire_lock;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en        <= 1'b0;
      reload    <= 8'hFF;
      count     <= 8'd0;
      presc     <= 16'd0;
      pulse_cnt <= 8'd0;
      in_port   <= 8'd0;
    end else begin
      if (fire_any)     en <= 1'b0;
      else if (wr_ctrl) en <= out_port[0];

      if (wr_reload) reload <= out_port;

      if (state == S_IDLE && state_n == S_RUN) begin
        count <= reload;
        presc <= 16'd0;
      end else if (state == S_RUN) begin
        if (fire_any) begin
          count <= 8'd0;
          presc <= 16'd0;
        end else if (kick_ok) begin
          count <= reload;
          presc <= 16'd0;
        end else begin
          presc <= tick ? 16'd0 : presc + 16'd1;
          if (tick && count != 8'd0) count <= count - 8'd1;
        end
      end else begin
        presc <= 16'd0;
      end

      pulse_cnt <= (state == S_FIRE) ? pulse_cnt + 8'd1 : 8'd0;

      case (sel)
        8'd0:    in_port <= {6'd0, lockmon, en};
        8'd1:    in_port <= reload;
        8'd2:    in_port <= count;
        8'd3:    in_port <= {5'd0, running, lock_cause, wdt_cause};
        default: in_port <= 8'd0;
      endcase
    end
  end

  // Cause bits deliberately ignore reset so firmware can read them afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fire_wdt)                      wdt_cause <= 1'b1;
      else if (wr_status && out_port[0]) wdt_cause <= 1'b0;
    end
  end

  assign reset_req = (state == S_FIRE);
  assign running   = (state == S_RUN);

endmodule

// File: tb/tb_wdt_reset_requester.sv
// Self-checking bench for wdt_reset_requester: directed scenarios plus random
// traffic against a deadline-based reference model.
module tb_wdt_reset_requester;

  localparam logic [7:0] BASE = 8'h40;
  localparam int P = 10;
  localparam int L = 16;
`ifdef WDT_LOCK_MONITOR_EN
  localparam bit LM = 1'b1;
`else
  localparam bit LM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] port_id = 8'd0;
  logic [7:0] out_port = 8'd0;
  logic       write_strobe = 1'b0;
  logic       locked = 1'b1;
  logic [7:0] in_port;
  logic       reset_req;
  logic       running;

  int checks = 0;
  int errors = 0;

  wdt_reset_requester #(.BASE_PORT(BASE), .PRESCALE(P), .PULSE_LEN(L)) dut (
    .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .locked(locked), .in_port(in_port),
    .reset_req(reset_req), .running(running)
  );

  always #5 clk = ~clk;

  // Reference model: time-based deadlines rather than counters.
  int         n = 0;            // edges elapsed
  int         m_state = 0;      // 0 idle, 1 run, 2 fire
  bit         m_en = 0, m_lm = 0, m_wdt = 0, m_lock = 0;
  logic [7:0] m_reload = 8'hFF;
  int         m_t0 = 0, m_base = 0, m_hold = 0, m_fire_end = 0, m_low = 0;
  logic [7:0] m_inport = 8'd0;

  function automatic int m_count(input int t);
    int v;
    if (m_state != 1) return m_hold;
    v = m_base - (t - m_t0) / P;
    return (v < 0) ? 0 : v;
  endfunction

  task automatic model_edge(input bit ws, input logic [7:0] pid, input logic [7:0] d,
                            input bit lk, input bit rs);
    logic [7:0] s, rd;
    bit wr, dis, kick, term, lkf, fw, fire;
    n++;
    s = pid - BASE;
    case (s)
      8'd0:    rd = {6'd0, m_lm & LM, m_en};
      8'd1:    rd = m_reload;
      8'd2:    rd = 8'(m_count(n - 1));
      8'd3:    rd = {5'd0, m_state == 1, m_lock, m_wdt};
      default: rd = 8'd0;
    endcase
    if (rs) begin
      m_state = 0; m_en = 0; m_lm = 0; m_reload = 8'hFF; m_hold = 0; m_low = 0;
      m_inport = 8'd0;
      return;
    end
    wr = ws && (m_state != 2);
    fw = 0; fire = 0; lkf = 0;
    dis  = wr && s == 8'd0 && !d[0];
    kick = wr && s == 8'd2 && d == 8'hA5;
    if (m_state == 0) begin
      if (wr && s == 8'd0 && d[0]) begin m_state = 1; m_t0 = n; m_base = int'(m_reload); end
    end else if (m_state == 1) begin
      term = (n == m_t0 + (m_base + 1) * P);
      lkf  = LM && m_lm && !lk && (m_low >= 1);
      if (dis) begin
        m_hold = m_count(n); m_state = 0;
      end else if ((term && !kick) || lkf) begin
        fw = term && !kick; fire = 1;
        m_state = 2; m_fire_end = n + L; m_hold = 0; m_en = 0;
      end else if (kick) begin
        m_t0 = n; m_base = int'(m_reload);
      end
    end else if (n == m_fire_end) begin
      m_state = 0;
    end
    if (!fire && wr && s == 8'd0) begin m_en = d[0]; m_lm = d[1]; end
    if (wr && s == 8'd1) m_reload = d;
    if (wr && s == 8'd3) begin
      if (d[0]) m_wdt = 0;
      if (d[1] && !lkf) m_lock = 0;
    end
    if (fw) m_wdt = 1;
    if (lkf) m_lock = 1;
    m_low = lk ? 0 : m_low + 1;
    m_inport = rd;
  endtask

  task automatic cyc(input bit ws, input logic [7:0] pid, input logic [7:0] d,
                     input bit lk, input bit rs);
    write_strobe = ws; port_id = pid; out_port = d; locked = lk; reset = rs;
    @(posedge clk);
    model_edge(ws, pid, d, lk, rs);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 8'h00, 8'h00, 1, 0);
  endtask
  task automatic wreg(input logic [7:0] off, input logic [7:0] d);
    cyc(1, BASE + off, d, 1, 0);
  endtask
  task automatic rreg(input logic [7:0] off);
    cyc(0, BASE + off, 8'h00, 1, 0);
  endtask

  task automatic test_reset;
    cyc(0, 8'h00, 8'h00, 1, 1);
    cyc(0, 8'h00, 8'h00, 1, 1);
    checks++;
    if (in_port !== 8'h00 || reset_req !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got in=%h req=%b run=%b exp 00 0 0", in_port, reset_req, running);
    end
    cyc(0, BASE, 8'h00, 1, 0);
    checks++;
    if (in_port !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h exp 00", in_port); end
    rreg(1);
    checks++;
    if (in_port !== 8'hFF) begin errors++; $display("FAIL reset_reload got %h exp ff", in_port); end
    rreg(2);
    checks++;
    if (in_port !== 8'h00) begin errors++; $display("FAIL reset_count got %h exp 00", in_port); end
    rreg(3);
    checks++;
    if (in_port !== 8'h00) begin errors++; $display("FAIL reset_status got %h exp 00", in_port); end
  endtask

  task automatic test_timeout;
    int k, w;
    wreg(1, 8'd3);
    wreg(0, 8'h01);
    k = 0;
    while (k < 300) begin idle(1); k++; if (reset_req === 1'b1) break; end
    checks++;
    if (k != 40) begin errors++; $display("FAIL timeout_latency got %0d exp 40", k); end
    w = 1;
    while (w < 100) begin idle(1); if (reset_req !== 1'b1) break; w++; end
    checks++;
    if (w != L) begin errors++; $display("FAIL pulse_width got %0d exp %0d", w, L); end
    rreg(3);
    checks++;
    if (in_port !== 8'h01) begin errors++; $display("FAIL timeout_status got %h exp 01", in_port); end
    rreg(0);
    checks++;
    if (in_port !== 8'h00) begin errors++; $display("FAIL en_cleared got %h exp 00", in_port); end
    wreg(3, 8'h03);
    rreg(3);
    checks++;
    if (in_port !== 8'h00) begin errors++; $display("FAIL w1c_clear got %h exp 00", in_port); end
  endtask

  task automatic test_kick;
    wreg(1, 8'd3);
    wreg(0, 8'h01);
    for (int i = 0; i < 500; i++) begin
      if (i % 30 == 29) wreg(2, 8'hA5); else idle(1);
      checks++;
      if (reset_req !== 1'b0 || running !== 1'b1) begin
        errors++;
        $display("FAIL kicked_run cycle %0d got req=%b run=%b exp 0 1", i, reset_req, running);
      end
    end
    wreg(0, 8'h00);
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL disable got run=%b exp 0", running); end
  endtask

  task automatic test_wrong_key;
    int k;
    wreg(1, 8'd3);
    wreg(0, 8'h01);
    idle(10);
    wreg(2, 8'h5A);
    k = 11;
    while (k < 300) begin idle(1); k++; if (reset_req === 1'b1) break; end
    checks++;
    if (k != 40) begin errors++; $display("FAIL wrong_key_latency got %0d exp 40", k); end
    idle(L);
    wreg(3, 8'h03);
  endtask

  task automatic test_kick_terminal;
    wreg(1, 8'd3);
    wreg(0, 8'h01);
    idle(39);
    wreg(2, 8'hA5);
    checks++;
    if (reset_req !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL kick_terminal got req=%b run=%b exp 0 1", reset_req, running);
    end
    rreg(2);
    checks++;
    if (in_port !== 8'd3) begin errors++; $display("FAIL kick_reload_count got %h exp 03", in_port); end
    rreg(3);
    checks++;
    if (in_port !== 8'h04) begin errors++; $display("FAIL kick_terminal_status got %h exp 04", in_port); end
    wreg(0, 8'h00);
  endtask

  task automatic test_lock;
    wreg(1, 8'hFF);
    wreg(0, 8'h03);
`ifdef WDT_LOCK_MONITOR_EN
    cyc(0, 8'h00, 8'h00, 0, 0);
    idle(5);
    checks++;
    if (reset_req !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL lock_glitch got req=%b run=%b exp 0 1", reset_req, running);
    end
    cyc(0, 8'h00, 8'h00, 0, 0);
    cyc(0, 8'h00, 8'h00, 0, 0);
    checks++;
    if (reset_req !== 1'b1) begin errors++; $display("FAIL lock_loss got req=%b exp 1", reset_req); end
    idle(L + 1);
    rreg(3);
    checks++;
    if (in_port !== 8'h02) begin errors++; $display("FAIL lock_status got %h exp 02", in_port); end
    wreg(3, 8'h03);
    rreg(3);
    checks++;
    if (in_port !== 8'h00) begin errors++; $display("FAIL lock_clear got %h exp 00", in_port); end
`else
    rreg(0);
    checks++;
    if (in_port !== 8'h01) begin errors++; $display("FAIL lockmon_absent got %h exp 01", in_port); end
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 8'h00, 0, 0);
    checks++;
    if (reset_req !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL lock_ignored got req=%b run=%b exp 0 1", reset_req, running);
    end
    wreg(0, 8'h00);
    rreg(3);
    checks++;
    if (in_port !== 8'h00) begin errors++; $display("FAIL lock_status_absent got %h exp 00", in_port); end
`endif
  endtask

  task automatic test_reset_fire;
    int k;
    wreg(1, 8'd0);
    wreg(0, 8'h01);
    k = 0;
    while (k < 100 && reset_req !== 1'b1) begin idle(1); k++; end
    checks++;
    if (k != P) begin errors++; $display("FAIL reload0_latency got %0d exp %0d", k, P); end
    idle(3);
    cyc(0, 8'h00, 8'h00, 1, 1);
    checks++;
    if (reset_req !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fire got req=%b run=%b exp 0 0", reset_req, running);
    end
    rreg(3);
    checks++;
    if (in_port !== 8'h01) begin errors++; $display("FAIL cause_kept got %h exp 01", in_port); end
    wreg(3, 8'h03);
    rreg(3);
    checks++;
    if (in_port !== 8'h00) begin errors++; $display("FAIL cause_clear got %h exp 00", in_port); end
  endtask

  task automatic test_random;
    int r;
    logic [7:0] pid, d;
    bit ws, lk, rs;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      ws = 1'b1; pid = BASE; d = 8'h00;
      if (r < 55)      begin ws = 1'b0; pid = 8'(BASE + 8'($urandom_range(0, 3))); end
      else if (r < 58) begin pid = BASE + 8'd2; d = 8'hA5; end
      else if (r < 61) begin pid = BASE + 8'd2; d = 8'($urandom); end
      else if (r < 67) begin pid = BASE; d = {6'd0, 1'($urandom), ($urandom_range(0, 3) != 0)}; end
      else if (r < 71) begin pid = BASE + 8'd1; d = 8'($urandom_range(0, 5)); end
      else if (r < 75) begin pid = BASE + 8'd3; d = 8'($urandom); end
      else if (r < 92) begin ws = 1'b0; pid = 8'(8'h3E + 8'($urandom_range(0, 6))); end
      else             begin pid = 8'($urandom); d = 8'($urandom); end
      lk = ($urandom_range(0, 99) >= 8);
      rs = ($urandom_range(0, 999) < 3);
      cyc(ws, pid, d, lk, rs);
      checks++;
      if (reset_req !== (m_state == 2) || running !== (m_state == 1) || in_port !== m_inport) begin
        errors++;
        $display("FAIL random cycle %0d got req=%b run=%b in=%h exp %b %b %h",
                 i, reset_req, running, in_port, m_state == 2, m_state == 1, m_inport);
      end
    end
  endtask

  initial begin
    test_reset;
    test_timeout;
    test_kick;
    test_wrong_key;
    test_kick_terminal;
    test_lock;
    test_reset_fire;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
